key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/pong_pkg.sv | 17 +
 rtl/key_debounce.sv | 134 +++++++++++++
 rtl/key_conditioner.sv | 36 +++
 tb/tb_key_conditioner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and default timing constants for the pong board front end.
// Timing defaults assume the 65 MHz pixel clock.
package pong_pkg;

    typedef enum logic [1:0] {
        StReleased,
        StConfirmPress,
        StPressed,
        StConfirmRelease
    } key_state_e;

    localparam int unsigned PixelClkHz       = 65_000_000;
    localparam int unsigned DbCyclesDefault  = 325_000;      // 5 ms
    localparam int unsigned RptDelayDefault  = 32_500_000;   // 0.5 s
    localparam int unsigned RptPeriodDefault = 6_500_000;    // 0.1 s

endpackage

// File: rtl/key_debounce.sv
// Single pushbutton channel: 2-flop synchronizer, debounce FSM and auto-repeat timer.
// Raw key and debounced level are active-low; press/release are one-cycle pulses.
module key_debounce
    import pong_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = DbCyclesDefault,
    parameter int unsigned RPT_DELAY  = RptDelayDefault,
    parameter int unsigned RPT_PERIOD = RptPeriodDefault
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_raw,
    input  logic i_rpt_en,
    output logic o_key,
    output logic o_press,
    output logic o_release
);

    localparam int unsigned RptMax = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int unsigned DbW    = $clog2(DB_CYCLES + 1);
    localparam int unsigned RptW   = $clog2(RptMax + 1);

    localparam logic [DbW-1:0]  DbTarget     = DbW'(DB_CYCLES);
    localparam logic [RptW-1:0] DelayTarget  = RptW'(RPT_DELAY);
    localparam logic [RptW-1:0] PeriodTarget = RptW'(RPT_PERIOD);

    logic            r_sync1, r_sync2;
    key_state_e      r_state, w_state_d;
    logic [DbW-1:0]  r_db_cnt, w_db_cnt_d, w_db_inc;
    logic [RptW-1:0] r_rpt_cnt, w_rpt_cnt_d, w_rpt_inc, w_rpt_target;
    logic            r_rpt_first, w_rpt_first_d;
    logic            r_key, w_key_d;
    logic            r_press, w_press_d;
    logic            r_release, w_release_d;

    // Saturating increments: counters never wrap.
    assign w_db_inc     = (r_db_cnt == '1) ? r_db_cnt : r_db_cnt + DbW'(1);
    assign w_rpt_inc    = (r_rpt_cnt == '1) ? r_rpt_cnt : r_rpt_cnt + RptW'(1);
    assign w_rpt_target = r_rpt_first ? PeriodTarget : DelayTarget;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= StReleased;
            r_db_cnt    <= '0;
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b0;
            r_key       <= 1'b1;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
        end else begin
            r_sync1     <= i_key_raw;
            r_sync2     <= r_sync1;
            r_state     <= w_state_d;
            r_db_cnt    <= w_db_cnt_d;
            r_rpt_cnt   <= w_rpt_cnt_d;
            r_rpt_first <= w_rpt_first_d;
            r_key       <= w_key_d;
            r_press     <= w_press_d;
            r_release   <= w_release_d;
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_db_cnt_d     = r_db_cnt;
        w_rpt_cnt_d    = r_rpt_cnt;
        w_rpt_first_d  = r_rpt_first;
        w_key_d        = r_key;
        w_press_d      = 1'b0;
        w_release_d    = 1'b0;

        case (r_state)
            StReleased: begin
                if (!r_sync2) begin
                    w_state_d  = StConfirmPress;
                    w_db_cnt_d = '0;
                end
            end
            StConfirmPress: begin
                if (r_sync2) begin
                    w_state_d  = StReleased;
                    w_db_cnt_d = '0;
                end else if (w_db_inc == DbTarget) begin
                    w_state_d     = StPressed;
                    w_db_cnt_d    = '0;
                    w_rpt_cnt_d   = '0;
                    w_rpt_first_d = 1'b0;
                    w_key_d       = 1'b0;
                    w_press_d     = 1'b1;
                end else begin
                    w_db_cnt_d = w_db_inc;
                end
            end
            StPressed: begin
                // Repeat timer keeps running while disabled; only the pulse is gated.
                if (w_rpt_inc == w_rpt_target) begin
                    w_rpt_cnt_d   = '0;
                    w_rpt_first_d = 1'b1;
                    w_press_d     = i_rpt_en;
                end else begin
                    w_rpt_cnt_d = w_rpt_inc;
                end
                if (r_sync2) begin
                    w_state_d  = StConfirmRelease;
                    w_db_cnt_d = '0;
                end
            end
            StConfirmRelease: begin
                // Repeat timer is frozen here so a rejected glitch resumes it intact.
                if (!r_sync2) begin
                    w_state_d  = StPressed;
                    w_db_cnt_d = '0;
                end else if (w_db_inc == DbTarget) begin
                    w_state_d   = StReleased;
                    w_db_cnt_d  = '0;
                    w_key_d     = 1'b1;
                    w_release_d = 1'b1;
                end else begin
                    w_db_cnt_d = w_db_inc;
                end
            end
            default: begin
                w_state_d = StReleased;
            end
        endcase
    end

    assign o_key     = r_key;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/key_conditioner.sv
// Debounce and auto-repeat front end for N_KEYS independent active-low pushbuttons.
// KEYS drives the game/video stage directly.
module key_conditioner
    import pong_pkg::*;
#(
    parameter int unsigned N_KEYS     = 4,
    parameter int unsigned DB_CYCLES  = DbCyclesDefault,
    parameter int unsigned RPT_DELAY  = RptDelayDefault,
    parameter int unsigned RPT_PERIOD = RptPeriodDefault
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] KEYS_RAW,
    input  logic [N_KEYS-1:0] RPT_EN,
    output logic [N_KEYS-1:0] KEYS,
    output logic [N_KEYS-1:0] PRESS,
    output logic [N_KEYS-1:0] RELEASE
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .RPT_DELAY (RPT_DELAY),
            .RPT_PERIOD(RPT_PERIOD)
        ) u_key_debounce (
            .i_clk    (clk),
            .i_rst_n  (reset),
            .i_key_raw(KEYS_RAW[g]),
            .i_rpt_en (RPT_EN[g]),
            .o_key    (KEYS[g]),
            .o_press  (PRESS[g]),
            .o_release(RELEASE[g])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with DB_CYCLES=8, RPT_DELAY=20, RPT_PERIOD=5.
// Stimulus pushes expected pulse events (edge number, key, kind); a monitor pops and compares.
module tb_key_conditioner;

    localparam int KindAccept  = 0;
    localparam int KindRepeat  = 1;
    localparam int KindRelease = 2;

    typedef struct {
        int cyc;
        int key;
        int kind;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] keys_raw;
    logic [3:0] rpt_en;
    logic [3:0] keys;
    logic [3:0] press;
    logic [3:0] release_o;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    logic [3:0] exp_level = 4'hF;
    int   mon_idx;
    ev_t  mon_ev;

    key_conditioner #(
        .N_KEYS    (4),
        .DB_CYCLES (8),
        .RPT_DELAY (20),
        .RPT_PERIOD(5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .KEYS_RAW(keys_raw),
        .RPT_EN  (rpt_en),
        .KEYS    (keys),
        .PRESS   (press),
        .RELEASE (release_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every negedge, match pulses against the scoreboard and check levels.
    always @(negedge clk) begin
        if (!reset) begin
            exp_level = 4'hF;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (press[k] && release_o[k]) begin
                    checks++;
                    errors++;
                    $display("FAIL press_and_release k%0d: both high at cycle %0d, required at most one",
                             k, cyc);
                end else if (press[k] || release_o[k]) begin
                    checks++;
                    mon_idx = -1;
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (mon_idx < 0 && exp_q[i].key == k) mon_idx = i;
                    end
                    if (mon_idx < 0) begin
                        errors++;
                        $display("FAIL unexpected_event k%0d: got %s at cycle %0d, required none",
                                 k, release_o[k] ? "RELEASE" : "PRESS", cyc);
                    end else begin
                        mon_ev = exp_q[mon_idx];
                        exp_q.delete(mon_idx);
                        if (mon_ev.cyc != cyc ||
                            ((mon_ev.kind == KindRelease) != release_o[k])) begin
                            errors++;
                            $display("FAIL event k%0d: got %s at cycle %0d, required kind %0d at cycle %0d",
                                     k, release_o[k] ? "RELEASE" : "PRESS", cyc,
                                     mon_ev.kind, mon_ev.cyc);
                        end
                        if (mon_ev.kind == KindAccept)  exp_level[k] = 1'b0;
                        if (mon_ev.kind == KindRelease) exp_level[k] = 1'b1;
                    end
                end
            end
            checks++;
            if (keys !== exp_level) begin
                errors++;
                $display("FAIL keys_level: got %b at cycle %0d, required %b", keys, cyc, exp_level);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    function automatic void push(input int k, input int c, input int kind);
        ev_t e;
        e.cyc  = c;
        e.key  = k;
        e.kind = kind;
        exp_q.push_back(e);
    endfunction

    // Drive a raw level now; the next rising edge (cyc+1) is the first sample.
    function automatic int press_now(input int k);
        keys_raw[k] = 1'b0;
        push(k, cyc + 11, KindAccept);
        return cyc + 11;
    endfunction

    function automatic void release_now(input int k);
        keys_raw[k] = 1'b1;
        push(k, cyc + 11, KindRelease);
    endfunction

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int acc;
        reset    = 1'b0;
        keys_raw = 4'hF;
        rpt_en   = 4'h0;
        repeat (3) step();
        check4("reset_keys", keys, 4'hF);
        check4("reset_press", press, 4'h0);
        check4("reset_release", release_o, 4'h0);
        step();
        reset = 1'b1;
        repeat (3) step();

        // Clean press on key 0: accepted 10 edges after first low sample.
        acc = press_now(0);
        wait_until(acc + 5);
        release_now(0);
        repeat (15) step();

        // Key 1 low for only 7 samples: rejected.
        keys_raw[1] = 1'b0;
        repeat (7) step();
        keys_raw[1] = 1'b1;
        repeat (15) step();

        // Key 2 held with repeat enabled.
        rpt_en[2] = 1'b1;
        acc = press_now(2);
        for (int d = 20; d <= 50; d += 5) push(2, acc + d, KindRepeat);
        wait_until(acc + 50);
        release_now(2);
        repeat (15) step();

        // Key 2 held with repeat disabled: acceptance pulse only.
        rpt_en[2] = 1'b0;
        acc = press_now(2);
        wait_until(acc + 50);
        release_now(2);
        repeat (15) step();

        // Key 0 with a 3-sample release glitch: repeat timer frozen, not cleared.
        rpt_en[0] = 1'b1;
        acc = press_now(0);
        push(0, acc + 23, KindRepeat);
        push(0, acc + 28, KindRepeat);
        wait_until(acc + 16);
        keys_raw[0] = 1'b1;
        wait_until(acc + 19);
        keys_raw[0] = 1'b0;
        wait_until(acc + 27);
        release_now(0);
        repeat (15) step();
        rpt_en[0] = 1'b0;

        // Reset 4 cycles into confirmation on key 3, raw held low throughout.
        keys_raw[3] = 1'b0;
        acc = cyc + 1;
        wait_until(acc + 6);
        reset = 1'b0;
        #1;
        check4("midreset_keys", keys, 4'hF);
        check4("midreset_press", press, 4'h0);
        check4("midreset_release", release_o, 4'h0);
        repeat (3) step();
        reset = 1'b1;
        acc = cyc + 11;
        push(3, acc, KindAccept);
        wait_until(acc + 5);
        release_now(3);
        repeat (15) step();

        // All four keys on the same edge.
        for (int k = 0; k < 4; k++) acc = press_now(k);
        wait_until(acc + 5);
        for (int k = 0; k < 4; k++) release_now(k);
        repeat (20) step();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            foreach (exp_q[i])
                $display("FAIL missing_event k%0d: kind %0d required at cycle %0d, got none",
                         exp_q[i].key, exp_q[i].kind, exp_q[i].cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
